countdown_sequencer: RTL

Initiator-side controller for the 100 ms LFSR tick timer. It loads a two-digit BCD seconds value, drives `timer_enable` to the tick timer, and consumes the returned 100 ms `tick_in` pulses. It accumulates TICKS_PER_SEC ticks per second and decrements the BCD count to 00, then emits a single-cycle `expired` pulse. It sits between the game FSM (start/abort/pause) and the tick timer, and its digits feed the seven-segment display path.

---
 rtl/countdown_pkg.sv | 18 +
 rtl/bcd_digit_down.sv | 28 ++
 rtl/countdown_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown sequencer.
// State encoding, BCD limit, default tick count and a digit clamp helper.
package countdown_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam int TICKS_PER_SEC_DEF = 10;

   function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with load (clamped to 9) and borrow out.
// Ports: clk, rst (sync, active-low), load, load_val, dec -> digit, borrow, is_zero.
import countdown_pkg::*;

module bcd_digit_down (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic [3:0] digit,
   output logic       borrow,
   output logic       is_zero
);

   always_ff @(posedge clk) begin
      if (!rst)
         digit <= 4'd0;
      else if (load)
         digit <= bcd_clamp(load_val);
      else if (dec)
         digit <= is_zero ? BCD_MAX : digit - 4'd1;
   end

   assign is_zero = (digit == 4'd0);
   assign borrow  = dec & is_zero;

endmodule

// File: rtl/countdown_sequencer.sv
// Two-digit BCD seconds countdown driven by 100 ms ticks from the tick timer.
// Ports: clk, rst (sync, active-low), start, load_tens, load_ones, pause,
//   abort, tick_in -> timer_enable, tens, ones, busy, expired.
// Optional: COUNTDOWN_PAUSE_EN enables the pause input and PAUSED state.
import countdown_pkg::*;

module countdown_sequencer #(
   parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] load_tens,
   input  logic [3:0] load_ones,
   input  logic       pause,
   input  logic       abort,
   input  logic       tick_in,
   output logic       timer_enable,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       busy,
   output logic       expired
);

   localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_SEC - 1);

   state_t     state, state_n;
   logic [3:0] tick_cnt, cnt_n;
   logic       exp_n;
   logic       pause_on;
   logic       load, load_zero;
   logic       wrap, final_tick;
   logic       dec_ones, borrow_ones, borrow_tens;
   logic       ones_zero, tens_zero;

`ifdef COUNTDOWN_PAUSE_EN
   assign pause_on = pause;
`else
   logic unused_pause;
   assign unused_pause = pause;
   assign pause_on     = 1'b0;
`endif

   assign load      = (state == IDLE) & start;
   assign load_zero = (load_tens == 4'd0) & (load_ones == 4'd0);
   assign wrap      = (state == RUN) & tick_in & (tick_cnt == TICK_LAST);

   // Last second ends when 01 decrements; this beats a concurrent pause.
   assign final_tick = wrap & tens_zero & ~ones_zero
                     & (ones[3:1] == 3'd0);

   assign dec_ones = ~abort & wrap & (final_tick | ~pause_on);

   bcd_digit_down u_ones (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_ones),
      .dec      (dec_ones),
      .digit    (ones),
      .borrow   (borrow_ones),
      .is_zero  (ones_zero)
   );

   bcd_digit_down u_tens (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_tens),
      .dec      (borrow_ones),
      .digit    (tens),
      .borrow   (borrow_tens),
      .is_zero  (tens_zero)
   );

   logic unused_borrow;
   assign unused_borrow = borrow_tens;

   always_comb begin
      state_n = state;
      cnt_n   = tick_cnt;
      exp_n   = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_n = 4'd0;
            if (start) begin
               state_n = load_zero ? IDLE : RUN;
               exp_n   = load_zero;
            end
         end
         RUN: begin
            if (abort) begin
               state_n = IDLE;
               cnt_n   = 4'd0;
            end else if (final_tick) begin
               state_n = IDLE;
               cnt_n   = 4'd0;
               exp_n   = 1'b1;
            end else if (pause_on) begin
               state_n = PAUSED;
            end else if (tick_in) begin
               cnt_n = wrap ? 4'd0 : tick_cnt + 4'd1;
            end
         end
`ifdef COUNTDOWN_PAUSE_EN
         PAUSED: begin
            if (abort) begin
               state_n = IDLE;
               cnt_n   = 4'd0;
            end else if (!pause) begin
               state_n = RUN;
            end
         end
`endif
         default: begin
            state_n = IDLE;
            cnt_n   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         tick_cnt     <= 4'd0;
         expired      <= 1'b0;
         timer_enable <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_n;
         tick_cnt     <= cnt_n;
         expired      <= exp_n;
         timer_enable <= (state_n == RUN);
         busy         <= (state_n != IDLE);
      end
   end

endmodule
